// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if: bundles every non-clock/reset signal of the VRAM arbiter.
//   timing : hBeginActive, hEndActive, line_base       (counters -> arbiter)
//   fetch  : fetch_valid, fetch_data                    (arbiter -> pixel shifter)
//   host   : host_req/we/addr/wdata -> host_ack/rdata   (CPU port)
//   mem    : mem_en/we/addr/wdata -> mem_rdata          (arbiter <-> VRAM)
// Modport slave is the arbiter side; master is the surrounding system.
interface vram_arbiter_if #(
    parameter int unsigned ADDR_W = 15,
    parameter int unsigned DATA_W = 8
);
    logic              hBeginActive;
    logic              hEndActive;
    logic [ADDR_W-1:0] line_base;
    logic              fetch_valid;
    logic [DATA_W-1:0] fetch_data;
    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_ack;
    logic [DATA_W-1:0] host_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  hBeginActive, hEndActive, line_base,
        input  host_req, host_we, host_addr, host_wdata,
        input  mem_rdata,
        output fetch_valid, fetch_data,
        output host_ack, host_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output hBeginActive, hEndActive, line_base,
        output host_req, host_we, host_addr, host_wdata,
        output mem_rdata,
        input  fetch_valid, fetch_data,
        input  host_ack, host_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares a single-port synchronous VRAM between the display fetch path and a host.
// Inside the active window one fetch slot is reserved every FETCH_PERIOD clocks; all other
// cycles are free for the host, which waits at most one cycle when it collides with a fetch.
// Ports:
//   clk  : system/pixel clock
//   nrst : asynchronous active-low reset; all outputs read 0 while asserted
//   bus  : vram_arbiter_if.slave (timing strobes, fetch output, host port, RAM port)
module vram_arbiter #(
    parameter int unsigned ADDR_W       = 15,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned FETCH_PERIOD = 8
) (
    input logic           clk,
    input logic           nrst,
    vram_arbiter_if.slave bus
);
    localparam int unsigned PhW = (FETCH_PERIOD > 2) ? $clog2(FETCH_PERIOD) : 1;
    localparam logic [PhW-1:0] PhLast = PhW'(FETCH_PERIOD - 1);

    typedef enum logic [1:0] {HIdle, HRd, HAck} host_st_e;

    host_st_e          hst_q, hst_d;
    logic              active_q, active_d;
    logic [PhW-1:0]    phase_q, phase_d;
    logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
    logic              fetch_pend_q;
    logic              fetch_valid_q;
    logic [DATA_W-1:0] fetch_data_q;
    logic [DATA_W-1:0] host_rdata_q;
    logic              fetch_cycle;
    logic              host_issue;

    // nrst gating keeps the combinational RAM port quiet during reset even if a strobe or
    // request is already asserted.
    always_comb begin
        fetch_cycle = nrst & ~bus.hEndActive
                    & (bus.hBeginActive | (active_q & (phase_q == '0)));
        host_issue  = nrst & (hst_q == HIdle) & bus.host_req & ~fetch_cycle;
    end

    // Active window, slot phase and running fetch address.
    always_comb begin
        active_d     = active_q;
        phase_d      = phase_q;
        fetch_addr_d = fetch_addr_q;
        if (bus.hEndActive) begin
            active_d = 1'b0;
        end else if (bus.hBeginActive) begin
            // The opening cycle itself fetches line_base, so the next slot reads line_base+1.
            active_d     = 1'b1;
            phase_d      = PhW'(1);
            fetch_addr_d = bus.line_base + ADDR_W'(1);
        end else if (active_q) begin
            phase_d = (phase_q == PhLast) ? '0 : phase_q + PhW'(1);
            if (phase_q == '0) begin
                fetch_addr_d = fetch_addr_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            active_q     <= 1'b0;
            phase_q      <= '0;
            fetch_addr_q <= '0;
        end else begin
            active_q     <= active_d;
            phase_q      <= phase_d;
            fetch_addr_q <= fetch_addr_d;
        end
    end

    // Read-data pipeline: RAM data arrives one clock after the access cycle.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            fetch_pend_q  <= 1'b0;
            fetch_valid_q <= 1'b0;
            fetch_data_q  <= '0;
            host_rdata_q  <= '0;
        end else begin
            fetch_pend_q  <= fetch_cycle;
            fetch_valid_q <= fetch_pend_q;
            if (fetch_pend_q) begin
                fetch_data_q <= bus.mem_rdata;
            end
            if (hst_q == HRd) begin
                host_rdata_q <= bus.mem_rdata;
            end
        end
    end

    // Host FSM: state register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            hst_q <= HIdle;
        end else begin
            hst_q <= hst_d;
        end
    end

    // Host FSM: next state.
    always_comb begin
        hst_d = hst_q;
        unique case (hst_q)
            HIdle: begin
                if (host_issue) begin
                    hst_d = bus.host_we ? HAck : HRd;
                end
            end
            HRd:     hst_d = HAck;
            HAck:    hst_d = HIdle;
            default: hst_d = HIdle;
        endcase
    end

    // Host FSM and RAM port outputs.
    always_comb begin
        bus.mem_en      = fetch_cycle | host_issue;
        bus.mem_we      = host_issue & bus.host_we;
        bus.mem_addr    = '0;
        bus.mem_wdata   = '0;
        if (fetch_cycle) begin
            bus.mem_addr = bus.hBeginActive ? bus.line_base : fetch_addr_q;
        end else if (host_issue) begin
            bus.mem_addr  = bus.host_addr;
            bus.mem_wdata = bus.host_wdata;
        end
        bus.host_ack    = (hst_q == HAck);
        bus.host_rdata  = host_rdata_q;
        bus.fetch_valid = fetch_valid_q;
        bus.fetch_data  = fetch_data_q;
    end
endmodule
